fp_mul_sequencer: RTL

- Top-level operation sequencer for the multi-cycle FP32 multiplier datapath.
- Accepts a start request and steps the datapath through load, special-case classification, iterative significand multiply, normalize, round, post-round renormalize and exponent range check.
- Writes the result register and holds a valid/ready result handshake.
- Drives datapath enables and consumes datapath status flags; all outputs are Moore-decoded from the state register except where noted.

---
 rtl/fp_mul_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_sequencer.sv
// Operation sequencer for the multi-cycle FP32 multiplier: load, classify, iterative
// significand multiply, normalize, round, renormalize, range check, then result handshake.
module fp_mul_sequencer #(
  parameter int MULT_CYCLES = 24,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready_in,
  output logic             busy,
  input  logic             a_nan,
  input  logic             b_nan,
  input  logic             a_inf,
  input  logic             b_inf,
  input  logic             a_zero,
  input  logic             b_zero,
  input  logic             MLB_significand_mult,
  input  logic             round_carry,
  input  logic             exp_overflow,
  input  logic             exp_underflow,
  output logic             load_operands,
  output logic             mult_step_en,
  output logic [CNT_W-1:0] mult_count,
  output logic             inc_shift_en,
  output logic             enable_rounding,
  output logic             renorm_en,
  output logic [1:0]       result_sel,
  output logic             enable_reg,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [3:0]       state_dbg
);

  // state     | meaning
  // IDLE      | waiting for start, ready_in high
  // LOAD      | operands captured into the datapath
  // CLASSIFY  | NaN/inf/zero decode picks special result or multiply
  // MULT      | one shift-add step per cycle, MULT_CYCLES steps
  // NORM      | shift right when product MSB is set
  // ROUND     | round to nearest even
  // CARRY_CHK | rounding overflow decides on renormalize
  // RENORM    | post-round shift and exponent increment
  // RANGE     | exponent overflow/underflow overrides the result
  // WRITE     | result register write strobe
  // HOLD      | result_valid until the consumer takes it
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_CLASSIFY  = 4'd2,
    S_MULT      = 4'd3,
    S_NORM      = 4'd4,
    S_ROUND     = 4'd5,
    S_CARRY_CHK = 4'd6,
    S_RENORM    = 4'd7,
    S_RANGE     = 4'd8,
    S_WRITE     = 4'd9,
    S_HOLD      = 4'd10
  } state_t;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_ZERO   = 2'b01;
  localparam logic [1:0] SEL_INF    = 2'b10;
  localparam logic [1:0] SEL_NAN    = 2'b11;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [1:0]       sel, sel_nxt;

  logic any_nan, any_inf, any_zero;

  // Zero times infinity is invalid and therefore yields a NaN.
  assign any_nan  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
  assign any_inf  = a_inf | b_inf;
  assign any_zero = a_zero | b_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      sel   <= SEL_NORMAL;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sel_nxt   = sel;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          count_nxt = '0;
        end
      end
      S_LOAD: begin
        count_nxt = '0;
        state_nxt = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (any_nan) begin
          sel_nxt   = SEL_NAN;
          state_nxt = S_WRITE;
        end else if (any_inf) begin
          sel_nxt   = SEL_INF;
          state_nxt = S_WRITE;
        end else if (any_zero) begin
          sel_nxt   = SEL_ZERO;
          state_nxt = S_WRITE;
        end else begin
          sel_nxt   = SEL_NORMAL;
          state_nxt = S_MULT;
        end
      end
      S_MULT: begin
        if (count == LAST_STEP) begin
          count_nxt = '0;
          state_nxt = S_NORM;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      S_NORM:      state_nxt = S_ROUND;
      S_ROUND:     state_nxt = S_CARRY_CHK;
      S_CARRY_CHK: state_nxt = round_carry ? S_RENORM : S_RANGE;
      S_RENORM:    state_nxt = S_RANGE;
      S_RANGE: begin
        if (exp_overflow) begin
          sel_nxt = SEL_INF;
        end else if (exp_underflow) begin
          sel_nxt = SEL_ZERO;
        end
        state_nxt = S_WRITE;
      end
      S_WRITE:     state_nxt = S_HOLD;
      S_HOLD: begin
        if (result_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
        sel_nxt   = SEL_NORMAL;
      end
    endcase
  end

  assign ready_in        = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign load_operands   = (state == S_LOAD);
  assign mult_step_en    = (state == S_MULT);
  assign mult_count      = count;
  // Only output that looks at an input: the shift decision needs the live product MSB.
  assign inc_shift_en    = (state == S_NORM) & MLB_significand_mult;
  assign enable_rounding = (state == S_ROUND);
  assign renorm_en       = (state == S_RENORM);
  assign result_sel      = sel;
  assign enable_reg      = (state == S_WRITE);
  assign result_valid    = (state == S_HOLD);
  assign state_dbg       = state;

endmodule
